// File: rtl/serial_add_ctrl.sv
// Bit-serial W-bit adder: one full-adder cell (two half adders + OR) reused LSB-first over W cycles.
// Define SERIAL_ADD_CARRY_IN_EN to add an i_carry port that seeds the carry register.

module serial_add_half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module serial_add_ctrl #(
    parameter int unsigned W = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
`ifdef SERIAL_ADD_CARRY_IN_EN
    input  logic         i_carry,
`endif
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_sum,
    output logic         o_carry
);
    localparam int unsigned CntW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;

    logic accept, last, carry_seed;
    logic ha1_sum, ha1_carry, bit_sum, ha2_carry, carry_next;

`ifdef SERIAL_ADD_CARRY_IN_EN
    assign carry_seed = i_carry;
`else
    assign carry_seed = 1'b0;
`endif

    // DONE accepts a new request just like IDLE, enabling back-to-back operation
    assign accept = i_start && (state_q == StIdle || state_q == StDone);
    assign last   = (state_q == StRun) && (cnt_q == LastCnt);

    serial_add_half_adder u_ha1 (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .sum   (ha1_sum),
        .carry (ha1_carry)
    );

    serial_add_half_adder u_ha2 (
        .a     (ha1_sum),
        .b     (carry_q),
        .sum   (bit_sum),
        .carry (ha2_carry)
    );

    assign carry_next = ha1_carry | ha2_carry;

    // FSM: state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StRun;
            StRun:   if (last) state_d = StDone;
            StDone:  state_d = accept ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs decoded from registered state only
    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        unique case (state_q)
            StRun:   o_busy = 1'b1;
            StDone:  o_done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next state
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        if (accept) begin
            a_d     = i_a;
            b_d     = i_b;
            res_d   = '0;
            carry_d = carry_seed;
            cnt_d   = '0;
        end else if (state_q == StRun) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            res_d   = {bit_sum, res_q[W-1:1]};
            carry_d = carry_next;
            if (last) begin
                cnt_d  = '0;
                sum_d  = {bit_sum, res_q[W-1:1]};
                cout_d = carry_next;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign o_sum   = sum_q;
    assign o_carry = cout_q;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial W-bit adder controller that time-shares one full-adder cell, built from two HalfAdder instances plus an OR, across W clock cycles.
- Latches two operands on a start request and walks the bit position LSB-first, holding the running carry in a register.
- Reports the W-bit sum and the carry-out with a busy/done handshake.
- Sits between the board switch/button inputs and the LED/display outputs as the sequencing layer over the half-adder datapath.

Parameters:
- W, 4, operand and sum width in bits; legal range 2..32.

Ports:
- i_clk  in  1  system clock, rising-edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  start request; sampled on the rising edge.
- i_a  in  W  operand A; sampled only on the edge that accepts i_start.
- i_b  in  W  operand B; sampled only on the edge that accepts i_start.
- o_busy  out  1  high while an addition is in progress.
- o_done  out  1  one-cycle pulse when a result is produced.
- o_sum  out  W  result sum; holds until the next result.
- o_carry  out  1  result carry-out; holds until the next result.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Nothing changes between rising edges.
- Reset values: FSM=IDLE, bit counter=0, carry register=0, operand shift registers=0, o_busy=0, o_done=0, o_sum=0, o_carry=0.
- Reset mid-operation aborts the addition. No o_done is produced and o_sum/o_carry return to 0.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - i_start=1 accepts the request: latch i_a and i_b into shift registers, clear the bit counter, seed the carry (0, or see Optional Feature), go to RUN.
  - i_start=0 stays in IDLE.
- RUN (o_busy=1):
  - Each edge computes s = a0^b0^c and c' = (a0&b0)|((a0^b0)&c). HalfAdder #1 takes (a0,b0); HalfAdder #2 takes (HA1.sum, c); c' = HA1.carry | HA2.carry.
  - Each edge shifts s into the MSB of the result shift register, shifts the operand registers right, and increments the counter.
  - On the edge where the counter equals W-1, go to DONE.
  - At that same edge, load o_sum from the completed result register and o_carry from c'.
  - i_start is ignored in RUN, with no queuing.
- DONE (o_done=1 for exactly one cycle, o_busy=0):
  - i_start=1 is accepted exactly as in IDLE and goes to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- Latency: if i_start is accepted at edge k, o_done is high during the cycle after edge k+W, and o_sum/o_carry are valid from edge k+W.
- Throughput: one result per W+1 cycles with back-to-back starts.
- Width rules:
  - Counter width is clog2(W), minimum 1.
  - The counter wraps to 0 on RUN exit, never through overflow.
  - Sum is modulo 2^W; the overflow bit appears only on o_carry.
- Outputs are registered. o_busy and o_done are decoded from registered state, with no combinational path from the inputs.

Optional Feature:
- Macro: SERIAL_ADD_CARRY_IN_EN.
- Defined:
  - Adds port i_carry (in, 1), sampled together with i_a and i_b when i_start is accepted.
  - The carry register is seeded with i_carry, so the result is i_a+i_b+i_carry.
- Undefined:
  - No i_carry port; the carry seed is constant 0.
  - Port list is exactly as above.

Test Plan:
- W=4, reset 2 cycles, then i_start pulse with i_a=3, i_b=5 -> o_busy high for 4 cycles; o_done pulses once 4 edges after accept; o_sum=8, o_carry=0.
- W=4, i_a=15, i_b=1 -> o_sum=0, o_carry=1. Then i_a=10, i_b=6 -> o_sum=0, o_carry=1. Then i_a=0, i_b=0 -> o_sum=0, o_carry=0.
- Accept i_a=2, i_b=2, then raise i_start with i_a=9, i_b=9 during RUN -> request ignored; result o_sum=4, o_carry=0; exactly one o_done.
- Hold i_start=1 continuously with fixed i_a=7, i_b=7 -> o_done pulses every 5 cycles; o_sum=14, o_carry=0 each time; o_busy low only in DONE cycles.
- Assert i_reset for 1 cycle at the 2nd RUN cycle of 12+12 -> all outputs 0 at the next edge; no o_done; a new start of 1+1 gives o_sum=2.
- With SERIAL_ADD_CARRY_IN_EN: i_a=7, i_b=8, i_carry=1 -> o_sum=0, o_carry=1. Then i_a=1, i_b=1, i_carry=1 -> o_sum=3, o_carry=0.
